sine_gen_multi: RTL
===================

# sine_gen_multi

Parametrised, multi-channel successor to the single-channel recursive sine generator. NCH independent quadrature oscillators share one time-multiplexed signed multiplier; each channel is a fixed-point 2-D rotation driven by (cosW, sinW) coefficients from the frequency-to-trig stage. Per-channel load, amplitude and enable come from the config register file. The output is either one selected channel or the averaged sum of enabled channels, feeding uo_out / downstream DAC logic.

## Interface
- WL, 16, sample/coefficient width (signed)
- NCH, 4, channel count (power of 2, ≥2)
- FRAC, WL-2, coefficient fraction bits (Q2.FRAC)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  run frames while high
- load  in  1  one-cycle pulse: latch cosW/sinW/amp for channel load_ch
- load_ch  in  $clog2(NCH)  target channel of load
- cosW, sinW  in  WL  signed rotation coefficients (Q2.FRAC)
- amp  in  WL  signed initial amplitude (restart value of x)
- ch_enable  in  NCH  per-channel run enable
- mode  in  1  0 = average of enabled channels, 1 = selected channel
- sel  in  $clog2(NCH)  channel shown when mode=1
- sine  out  WL  current output sample
- sample_valid  out  1  one-cycle pulse when sine updates
- busy  out  1  high while a frame is in progress

## Operation
- Per channel state: x, y (WL), c, s (WL), pending flag + pending c/s/amp.
- load: writes pending registers of load_ch, sets pending flag; later load to same channel before apply overwrites (last wins). load during processing of that channel is applied next frame.
- FSM: IDLE → CH_INIT → P0 → P1 → P2 → P3 → (next channel CH_INIT… ) → OUT → IDLE or CH_INIT(ch 0) if en.
  - CH_INIT folded into P0 cycle (no extra cycle): if pending, x←amp, y←0, c/s←pending, clear flag, before products.
  - P0: acc←x·c; P1: x_new←rnd(acc − y·s); P2: acc←x·s; P3: y←rnd(acc + y·c), x←x_new.
  - Disabled channel: cycles still consumed, x/y held, pending still applied, contributes 0.
- rnd(): 2WL product sum, add 2^(FRAC-1), arithmetic shift right FRAC, saturate to [−2^(WL-1), 2^(WL-1)−1].
- Mixing: sum of y of enabled channels in WL+log2(NCH) bits, arithmetic shift right log2(NCH). mode=1: y of sel (even if disabled → held value).
- en low mid-frame: frame completes, FSM returns to IDLE, state held.
- mode/sel/ch_enable sampled in OUT cycle only.

## Timing
- Frame = 4·NCH + 1 cycles (17 for NCH=4); sine and sample_valid registered in OUT cycle, visible next edge.
- en rising in IDLE: busy high next cycle; first sample_valid 4·NCH+1 cycles after start.
- Continuous en: sample_valid every 4·NCH+1 cycles, no gaps.
- Reset values: sine=0, sample_valid=0, busy=0, all x/y/c/s=0, pending flags=0, FSM IDLE. Reset mid-frame aborts immediately.

## Structure
- Package sine_gen_pkg: FSM state enum, FRAC default, rounding/saturation function, NCH log2 constant.
- Sub-module rot_mac: single WL×WL signed multiplier, add/sub accumulator, round-and-saturate; FSM and channel storage stay in top.

## Test plan
- Reset: drive rst_n low mid-frame → sine=0, sample_valid=0, busy=0 asynchronously; restart gives clean 17-cycle frames.
- 90° rotation: WL=16, ch0 load cosW=0, sinW=0x4000, amp=0x1000, mode=1, sel=0 → sine 0x1000, 0x0000, 0xF000, 0x0000, repeating; sample_valid spacing exactly 17 cycles.
- Averaging: ch0 and ch1 loaded as above, ch_enable=4'b0011, mode=0 → sine 0x0800, 0, 0xF800, 0; ch_enable=4'b0001 → 0x0400 sequence.
- Saturation/rounding: cosW=0x7FFF, sinW=0x7FFF, amp=0x7FFF → y clamps to 0x7FFF, never wraps negative; rounding: amp=1, cosW=0, sinW=0x2000 → y=1 (0.5 rounds up).
- Load collision: two loads to ch2 within a frame (second sinW=0x4000) → only second values take effect next frame; load to ch1 during its P1 → applied following frame.
- en drop mid-frame: en low at cycle 5 → frame finishes, one sample_valid, busy low, state held; en high resumes sequence with no phase jump.

Source files
------------

// File: rtl/sine_gen_pkg.sv
// rtl/sine_gen_pkg.sv - shared constants, FSM state codes and fixed-point helper for sine_gen_multi
//
// Contents:
//   DEF_WL / DEF_FRAC / DEF_NCH / DEF_NCH_LOG2  default widths and channel count
//   ST_*                                       frame sequencer state codes
//   mac_op_t                                   operation select for rot_mac
//   rnd_sat()                                  round-half-up, arithmetic shift, saturate
package sine_gen_pkg;

  localparam int DEF_WL       = 16;
  localparam int DEF_FRAC     = DEF_WL - 2;
  localparam int DEF_NCH      = 4;
  localparam int DEF_NCH_LOG2 = $clog2(DEF_NCH);

  // Channel init is folded into P0, so there is no separate CH_INIT code.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_P0   = 3'd1;
  localparam logic [2:0] ST_P1   = 3'd2;
  localparam logic [2:0] ST_P2   = 3'd3;
  localparam logic [2:0] ST_P3   = 3'd4;
  localparam logic [2:0] ST_OUT  = 3'd5;

  typedef enum logic [1:0] {
    MAC_HOLD,  // accumulator untouched
    MAC_LOAD,  // acc <= a*b
    MAC_SUB,   // result = rnd(acc - a*b)
    MAC_ADD    // result = rnd(acc + a*b)
  } mac_op_t;

  // Adds 2^(frac-1), shifts right arithmetically by frac and clamps to a
  // signed wl-bit range. Callers pass constant wl/frac, so this folds to
  // a fixed adder, shifter and comparator pair.
  function automatic logic signed [63:0] rnd_sat(input logic signed [63:0] v,
                                                  input int wl,
                                                  input int frac);
    logic signed [63:0] t;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] r;
    t  = (v + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (wl - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (wl - 1));
    if (t > hi)      r = hi;
    else if (t < lo) r = lo;
    else             r = t;
    return r;
  endfunction

endpackage

// File: rtl/sine_gen_multi_rot_mac.sv
// rtl/sine_gen_multi_rot_mac.sv - shared signed multiplier with accumulator and round/saturate
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   a, b        signed WL-bit operands
//   op          MAC_LOAD stores a*b; MAC_SUB / MAC_ADD combine it with the stored value
//   res         rnd_sat(acc -/+ a*b), valid combinationally during MAC_SUB / MAC_ADD
module rot_mac
  import sine_gen_pkg::*;
#(
  parameter int WL   = DEF_WL,
  parameter int FRAC = WL - 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [WL-1:0] a,
  input  logic signed [WL-1:0] b,
  input  mac_op_t              op,
  output logic        [WL-1:0] res
);

  // One guard bit above the 2*WL product: the sum of two full-scale
  // products (e.g. 0x7FFF*0x7FFF twice) must not wrap before saturation.
  localparam int AW = 2 * WL + 1;

  logic signed [2*WL-1:0] prod;
  logic signed [AW-1:0]   prod_x;
  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   sum;
  logic signed [63:0]     sum_x;

  assign prod   = a * b;
  assign prod_x = AW'(prod);

  always_comb begin
    sum = acc + prod_x;
    if (op == MAC_SUB) sum = acc - prod_x;
  end

  assign sum_x = 64'(sum);
  assign res   = WL'(rnd_sat(sum_x, WL, FRAC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               acc <= '0;
    else if (op == MAC_LOAD)  acc <= prod_x;
  end

endmodule

// File: rtl/sine_gen_multi.sv
// rtl/sine_gen_multi.sv - NCH time-multiplexed quadrature oscillators with mix/select output
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   en               run frames while high; a frame always completes once started
//   load, load_ch    one-cycle pulse latching cosW/sinW/amp as pending for load_ch
//   cosW, sinW       signed Q2.FRAC rotation coefficients
//   amp              signed restart value of x (y restarts at 0)
//   ch_enable        per-channel run enable (disabled channels hold x/y, mix as 0)
//   mode, sel        0: average of enabled channels, 1: y of channel sel
//   sine             output sample, updated once per frame
//   sample_valid     one-cycle pulse when sine updates
//   busy             high while a frame is in progress
module sine_gen_multi
  import sine_gen_pkg::*;
#(
  parameter int WL   = DEF_WL,
  parameter int NCH  = DEF_NCH,
  parameter int FRAC = WL - 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   load,
  input  logic [$clog2(NCH)-1:0] load_ch,
  input  logic [WL-1:0]          cosW,
  input  logic [WL-1:0]          sinW,
  input  logic [WL-1:0]          amp,
  input  logic [NCH-1:0]         ch_enable,
  input  logic                   mode,
  input  logic [$clog2(NCH)-1:0] sel,
  output logic [WL-1:0]          sine,
  output logic                   sample_valid,
  output logic                   busy
);

  localparam int            LG      = $clog2(NCH);
  localparam logic [LG-1:0] LAST_CH = LG'(NCH - 1);

  logic [2:0]    state;
  logic [LG-1:0] ch;

  logic [WL-1:0] x_q  [NCH];
  logic [WL-1:0] y_q  [NCH];
  logic [WL-1:0] c_q  [NCH];
  logic [WL-1:0] s_q  [NCH];
  logic [WL-1:0] pc_q [NCH];
  logic [WL-1:0] ps_q [NCH];
  logic [WL-1:0] pa_q [NCH];
  logic [NCH-1:0] pend;
  logic [WL-1:0]  xn_q;

  logic [WL-1:0] mac_a;
  logic [WL-1:0] mac_b;
  logic [WL-1:0] mac_res;
  mac_op_t       mac_op;

  logic signed [WL+LG-1:0] mix_sum;

  assign busy = (state != ST_IDLE);

  // Frame sequencer: four cycles per channel, then one output cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ch    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (en) begin
          state <= ST_P0;
          ch    <= '0;
        end
        ST_P0: state <= ST_P1;
        ST_P1: state <= ST_P2;
        ST_P2: state <= ST_P3;
        ST_P3: begin
          if (ch == LAST_CH) begin
            state <= ST_OUT;
          end else begin
            state <= ST_P0;
            ch    <= ch + LG'(1);
          end
        end
        ST_OUT: begin
          ch    <= '0;
          state <= en ? ST_P0 : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Operand steering. In P0 a pending load is used directly, so the first
  // product of a freshly loaded channel already sees amp/cosW.
  always_comb begin
    mac_a  = '0;
    mac_b  = '0;
    mac_op = MAC_HOLD;
    case (state)
      ST_P0: begin
        mac_a  = pend[ch] ? pa_q[ch] : x_q[ch];
        mac_b  = pend[ch] ? pc_q[ch] : c_q[ch];
        mac_op = MAC_LOAD;
      end
      ST_P1: begin
        mac_a  = y_q[ch];
        mac_b  = s_q[ch];
        mac_op = MAC_SUB;
      end
      ST_P2: begin
        mac_a  = x_q[ch];
        mac_b  = s_q[ch];
        mac_op = MAC_LOAD;
      end
      ST_P3: begin
        mac_a  = y_q[ch];
        mac_b  = c_q[ch];
        mac_op = MAC_ADD;
      end
      default: ;
    endcase
  end

  rot_mac #(
    .WL   (WL),
    .FRAC (FRAC)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (mac_a),
    .b     (mac_b),
    .op    (mac_op),
    .res   (mac_res)
  );

  // Channel state. A load landing in the same cycle as that channel's P0
  // keeps its pending flag set: the apply consumes the older values and the
  // new ones wait for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        x_q[i]  <= '0;
        y_q[i]  <= '0;
        c_q[i]  <= '0;
        s_q[i]  <= '0;
        pc_q[i] <= '0;
        ps_q[i] <= '0;
        pa_q[i] <= '0;
      end
      pend <= '0;
      xn_q <= '0;
    end else begin
      if (state == ST_P0 && pend[ch]) begin
        x_q[ch]  <= pa_q[ch];
        y_q[ch]  <= '0;
        c_q[ch]  <= pc_q[ch];
        s_q[ch]  <= ps_q[ch];
        pend[ch] <= 1'b0;
      end
      if (state == ST_P1) xn_q <= mac_res;
      // x is committed together with y so P2 still rotates the old x.
      if (state == ST_P3 && ch_enable[ch]) begin
        x_q[ch] <= xn_q;
        y_q[ch] <= mac_res;
      end
      if (load) begin
        pc_q[load_ch] <= cosW;
        ps_q[load_ch] <= sinW;
        pa_q[load_ch] <= amp;
        pend[load_ch] <= 1'b1;
      end
    end
  end

  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_enable[i]) mix_sum = mix_sum + (WL+LG)'($signed(y_q[i]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sine         <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= (state == ST_OUT);
      if (state == ST_OUT) sine <= mode ? y_q[sel] : WL'(mix_sum >>> LG);
    end
  end

endmodule
